axis_frame_source: RTL and testbench
====================================

AXIS_FRAME_SOURCE -- requirements
Module: axis_frame_source

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, pixel width in bits.
REQ-002 SHALL have parameter FRAME_WIDTH, default 640, pixels per line.
REQ-003 SHALL have parameter FRAME_HEIGHT, default 512, lines per frame.
REQ-004 SHALL have parameter H_BLANK, default 0, idle cycles (tvalid=0) after each line except the last.
REQ-005 SHALL have parameter V_BLANK, default 0, idle cycles after the last line before the next frame in continuous mode.
REQ-006 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port start  input  1  one-cycle request to begin a frame.
REQ-009 SHALL have port continuous  input  1  1 = start a new frame automatically after each frame.
REQ-010 SHALL have port mode  input  2  pattern select.
REQ-011 SHALL have port const_value  input  DATA_WIDTH  pixel value for mode 1.
REQ-012 SHALL have port m_axis_tdata  output  DATA_WIDTH  pixel.
REQ-013 SHALL have port m_axis_tvalid  output  1  beat valid.
REQ-014 SHALL have port m_axis_tlast  output  1  last pixel of line.
REQ-015 SHALL have port m_axis_tuser  output  1  first pixel of frame.
REQ-016 SHALL have port m_axis_tready  input  1  downstream ready.
REQ-017 SHALL have port busy  output  1  high from frame start until return to IDLE.
REQ-018 SHALL have port frame_done  output  1  one-cycle pulse after the last beat of each frame is accepted.

Function
REQ-019 SHALL implement FSM states IDLE, ACTIVE, HBLANK, VBLANK; all outputs registered.
REQ-020 SHALL, in IDLE with start=1, latch mode, const_value and continuous, clear row/col, and enter ACTIVE; m_axis_tvalid rises the next cycle (1-cycle latency).
REQ-021 SHALL ignore start when not in IDLE.
REQ-022 SHALL count a beat only when m_axis_tvalid && m_axis_tready in the same cycle.
REQ-023 SHALL hold tdata, tlast, tuser and tvalid stable while tvalid=1 and tready=0; tvalid never drops without a transfer.
REQ-024 SHALL generate tdata per latched mode: 0 = (row+col) mod 2^DATA_WIDTH; 1 = const_value; 2 = col mod 2^DATA_WIDTH; 3 = row mod 2^DATA_WIDTH.
REQ-025 SHALL assert tuser only with row=0,col=0, and tlast only with col=FRAME_WIDTH-1.
REQ-026 SHALL, on accepted beat with col<FRAME_WIDTH-1, increment col; with col=FRAME_WIDTH-1 and row<FRAME_HEIGHT-1, clear col, increment row, enter HBLANK if H_BLANK>0 else stay ACTIVE with no bubble.
REQ-027 SHALL hold tvalid=0 for exactly H_BLANK cycles in HBLANK, then return to ACTIVE.
REQ-028 SHALL, on accepted last beat of frame (row=FRAME_HEIGHT-1, col=FRAME_WIDTH-1), pulse frame_done the next cycle and: if latched continuous=0 go IDLE; else enter VBLANK if V_BLANK>0 else ACTIVE at row=0,col=0 with no bubble.
REQ-029 SHALL, at each new frame in continuous mode, re-latch mode, const_value and continuous; continuous=0 sampled there ends the run after that frame.
REQ-030 SHALL keep busy=1 in ACTIVE, HBLANK, VBLANK; busy=0 in IDLE (busy falls with frame_done of the final frame).
REQ-031 SHALL size row/col counters to $clog2 of FRAME_HEIGHT/FRAME_WIDTH (minimum 1 bit) and blank counter to cover max(H_BLANK,V_BLANK).

Reset
REQ-032 SHALL, while rst_n=0, force IDLE, counters 0, m_axis_tvalid=0, tdata=0, tlast=0, tuser=0, busy=0, frame_done=0, regardless of clock.
REQ-033 SHALL, on reset mid-frame, abandon the frame; the first frame after release begins with tuser=1 at row 0,col 0.

Verification (FRAME_WIDTH=4, FRAME_HEIGHT=3, DATA_WIDTH=8)
REQ-034 Mode 0, tready=1, H_BLANK=0 -> 12 consecutive beats 0,1,2,3,1,2,3,4,2,3,4,5; tuser on beat 1; tlast on beats 4,8,12; frame_done 1 cycle after beat 12; busy=0 thereafter.
REQ-035 Mode 1, const_value=0xA5, tready toggling 1/0 each cycle -> 12 beats all 0xA5, outputs stable during every tready=0 cycle, no beat lost or duplicated.
REQ-036 H_BLANK=2, tready=1 -> exactly 2 tvalid=0 cycles after beats 4 and 8, none after beat 12.
REQ-037 continuous=1, V_BLANK=3, mode 3 -> frames back-to-back separated by 3 idle cycles, second frame tuser=1, data rows 0,0,0,0,1,1,1,1,2,2,2,2; drop continuous -> IDLE after current frame.
REQ-038 Assert rst_n=0 at beat 6 while tready=0 -> tvalid=0 immediately (asynchronously); after release and start, frame restarts at tdata=0 with tuser=1.
REQ-039 start pulsed during ACTIVE -> no effect; exactly one frame of 12 beats and one frame_done.

Source files
------------

// File: rtl/axis_frame_source.sv
// AXI4-Stream test-pattern frame generator: one pixel per accepted beat, tuser on
// the first pixel of a frame, tlast on the last pixel of each line, optional blanking.
module axis_frame_source #(
    parameter int DATA_WIDTH   = 8,
    parameter int FRAME_WIDTH  = 640,
    parameter int FRAME_HEIGHT = 512,
    parameter int H_BLANK      = 0,
    parameter int V_BLANK      = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [1:0]            mode,
    input  logic [DATA_WIDTH-1:0] const_value,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  frame_done
);
    localparam int CW   = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
    localparam int RW   = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
    localparam int BMAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int BW   = (BMAX > 1) ? $clog2(BMAX) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(FRAME_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_HEIGHT - 1);
    localparam logic [BW-1:0] H_LAST   = BW'((H_BLANK > 0) ? H_BLANK - 1 : 0);
    localparam logic [BW-1:0] V_LAST   = BW'((V_BLANK > 0) ? V_BLANK - 1 : 0);
    localparam logic          ONE_COL  = (FRAME_WIDTH == 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} state_t;

    state_t                state_q;
    logic [RW-1:0]         row_q;
    logic [CW-1:0]         col_q;
    logic [BW-1:0]         blank_q;
    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] const_q;
    logic                  cont_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tvalid_q;
    logic                  tlast_q;
    logic                  tuser_q;
    logic                  busy_q;
    logic                  done_q;

    logic [CW-1:0]         col_d;
    logic [RW-1:0]         row_d;
    logic                  accept;

    function automatic logic [DATA_WIDTH-1:0] pixel(input logic [1:0] m,
                                                    input logic [DATA_WIDTH-1:0] cv,
                                                    input logic [RW-1:0] r,
                                                    input logic [CW-1:0] c);
        case (m)
            2'd0:    return DATA_WIDTH'(r) + DATA_WIDTH'(c);
            2'd1:    return cv;
            2'd2:    return DATA_WIDTH'(c);
            default: return DATA_WIDTH'(r);
        endcase
    endfunction

    always_comb begin
        col_d  = col_q + 1'b1;
        row_d  = row_q + 1'b1;
        accept = tvalid_q && m_axis_tready;
    end

    // The output registers always hold the beat at (row_q, col_q); they are only
    // reloaded on an accepted beat or when a blank/frame start presents a new beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            blank_q  <= '0;
            mode_q   <= '0;
            const_q  <= '0;
            cont_q   <= 1'b0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tuser_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        mode_q   <= mode;
                        const_q  <= const_value;
                        cont_q   <= continuous;
                        row_q    <= '0;
                        col_q    <= '0;
                        state_q  <= ACTIVE;
                        busy_q   <= 1'b1;
                        tvalid_q <= 1'b1;
                        tdata_q  <= pixel(mode, const_value, '0, '0);
                        tuser_q  <= 1'b1;
                        tlast_q  <= ONE_COL;
                    end
                end
                ACTIVE: begin
                    if (accept) begin
                        if (col_q != COL_LAST) begin
                            col_q   <= col_d;
                            tdata_q <= pixel(mode_q, const_q, row_q, col_d);
                            tuser_q <= 1'b0;
                            tlast_q <= (col_d == COL_LAST);
                        end else if (row_q != ROW_LAST) begin
                            col_q   <= '0;
                            row_q   <= row_d;
                            tdata_q <= pixel(mode_q, const_q, row_d, '0);
                            tuser_q <= 1'b0;
                            tlast_q <= ONE_COL;
                            if (H_BLANK > 0) begin
                                state_q  <= HBLANK;
                                tvalid_q <= 1'b0;
                                blank_q  <= '0;
                            end
                        end else begin
                            done_q <= 1'b1;
                            row_q  <= '0;
                            col_q  <= '0;
                            if (!cont_q) begin
                                state_q  <= IDLE;
                                busy_q   <= 1'b0;
                                tvalid_q <= 1'b0;
                                tdata_q  <= '0;
                                tuser_q  <= 1'b0;
                                tlast_q  <= 1'b0;
                            end else if (V_BLANK > 0) begin
                                state_q  <= VBLANK;
                                tvalid_q <= 1'b0;
                                blank_q  <= '0;
                                tuser_q  <= 1'b0;
                                tlast_q  <= 1'b0;
                            end else begin
                                mode_q  <= mode;
                                const_q <= const_value;
                                cont_q  <= continuous;
                                tdata_q <= pixel(mode, const_value, '0, '0);
                                tuser_q <= 1'b1;
                                tlast_q <= ONE_COL;
                            end
                        end
                    end
                end
                HBLANK: begin
                    if (blank_q == H_LAST) begin
                        state_q  <= ACTIVE;
                        tvalid_q <= 1'b1;
                    end else begin
                        blank_q <= blank_q + 1'b1;
                    end
                end
                VBLANK: begin
                    if (blank_q == V_LAST) begin
                        mode_q   <= mode;
                        const_q  <= const_value;
                        cont_q   <= continuous;
                        state_q  <= ACTIVE;
                        tvalid_q <= 1'b1;
                        tdata_q  <= pixel(mode, const_value, '0, '0);
                        tuser_q  <= 1'b1;
                        tlast_q  <= ONE_COL;
                    end else begin
                        blank_q <= blank_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;
endmodule

// File: tb/tb_axis_frame_source.sv
// Directed bench for axis_frame_source on a 4x3 frame: one DUT without line
// blanking (V_BLANK=3) and one with H_BLANK=2, driven from shared inputs.
module tb_axis_frame_source;
    logic       clk = 1'b0;
    logic       rst_n, start, continuous, tready;
    logic [1:0] mode;
    logic [7:0] const_value;

    logic [7:0] a_tdata, b_tdata;
    logic       a_tvalid, a_tlast, a_tuser, a_busy, a_done;
    logic       b_tvalid, b_tlast, b_tuser, b_busy, b_done;

    always #5 clk = ~clk;

    axis_frame_source #(.DATA_WIDTH(8), .FRAME_WIDTH(4), .FRAME_HEIGHT(3),
                        .H_BLANK(0), .V_BLANK(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .mode(mode), .const_value(const_value),
        .m_axis_tdata(a_tdata), .m_axis_tvalid(a_tvalid), .m_axis_tlast(a_tlast),
        .m_axis_tuser(a_tuser), .m_axis_tready(tready),
        .busy(a_busy), .frame_done(a_done));

    axis_frame_source #(.DATA_WIDTH(8), .FRAME_WIDTH(4), .FRAME_HEIGHT(3),
                        .H_BLANK(2), .V_BLANK(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .mode(mode), .const_value(const_value),
        .m_axis_tdata(b_tdata), .m_axis_tvalid(b_tvalid), .m_axis_tlast(b_tlast),
        .m_axis_tuser(b_tuser), .m_axis_tready(tready),
        .busy(b_busy), .frame_done(b_done));

    int         sel = 0;
    logic [7:0] s_tdata;
    logic       s_tvalid, s_tlast, s_tuser, s_busy, s_done;
    assign s_tdata  = (sel == 1) ? b_tdata  : a_tdata;
    assign s_tvalid = (sel == 1) ? b_tvalid : a_tvalid;
    assign s_tlast  = (sel == 1) ? b_tlast  : a_tlast;
    assign s_tuser  = (sel == 1) ? b_tuser  : a_tuser;
    assign s_busy   = (sel == 1) ? b_busy   : a_busy;
    assign s_done   = (sel == 1) ? b_done   : a_done;

    int tests = 0;
    int fails = 0;

    logic [7:0] bd [64];
    logic       bu [64];
    logic       bl [64];
    int         bc [64];
    int         dc [8];
    int         nbeat, ndone, viol;
    logic [7:0] e034 [12];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_frame();
        start  = 1'b1;
        tready = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
    endtask

    // rmode 0: tready always 1; rmode 1: tready high on even cycles only.
    task automatic capture(input int ncyc, input int rmode, input int drop_at, input int start_at);
        logic       prev_stall = 1'b0;
        logic [10:0] prev_vec  = '0;
        nbeat = 0; ndone = 0; viol = 0;
        for (int i = 0; i < ncyc; i++) begin
            tready = (rmode == 0) ? 1'b1 : ((i % 2) == 0);
            if (i == drop_at) continuous = 1'b0;
            start = (i == start_at);
            if (prev_stall && ({s_tdata, s_tvalid, s_tlast, s_tuser} !== prev_vec)) viol++;
            if (s_tvalid && tready && nbeat < 64) begin
                bd[nbeat] = s_tdata;
                bu[nbeat] = s_tuser;
                bl[nbeat] = s_tlast;
                bc[nbeat] = i;
                nbeat++;
            end
            if (s_done) begin
                if (ndone < 8) dc[ndone] = i;
                ndone++;
            end
            prev_stall = s_tvalid && !tready;
            prev_vec   = {s_tdata, s_tvalid, s_tlast, s_tuser};
            @(posedge clk); #1;
        end
        start  = 1'b0;
        tready = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((a_busy || b_busy) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, {31'd0, a_busy || b_busy}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; continuous = 1'b0; tready = 1'b0;
        mode = 2'd0; const_value = 8'h00;
        e034 = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd1, 8'd2, 8'd3, 8'd4, 8'd2, 8'd3, 8'd4, 8'd5};

        #22;
        chk("rst_a_tvalid", {31'd0, a_tvalid}, 32'd0);
        chk("rst_a_tdata",  {24'd0, a_tdata},  32'd0);
        chk("rst_a_tlast",  {31'd0, a_tlast},  32'd0);
        chk("rst_a_tuser",  {31'd0, a_tuser},  32'd0);
        chk("rst_a_busy",   {31'd0, a_busy},   32'd0);
        chk("rst_a_done",   {31'd0, a_done},   32'd0);
        chk("rst_b_tvalid", {31'd0, b_tvalid}, 32'd0);
        chk("rst_b_busy",   {31'd0, b_busy},   32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("[TB] step reset: done");

        // Mode 0 ramp, no stalls, no line blanking.
        sel = 0; mode = 2'd0; continuous = 1'b0;
        start_frame();
        capture(20, 0, -1, -1);
        chk("m0_nbeat", nbeat, 32'd12);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("m0_data%0d", k), {24'd0, bd[k]}, {24'd0, e034[k]});
            chk($sformatf("m0_user%0d", k), {31'd0, bu[k]}, {31'd0, k == 0});
            chk($sformatf("m0_last%0d", k), {31'd0, bl[k]}, {31'd0, (k % 4) == 3});
            chk($sformatf("m0_cyc%0d", k), bc[k], k);
        end
        chk("m0_ndone", ndone, 32'd1);
        chk("m0_done_cyc", dc[0], 32'd12);
        chk("m0_busy_end", {31'd0, s_busy}, 32'd0);
        $display("[TB] step mode0: beats=%0d done=%0d", nbeat, ndone);
        wait_idle("idle_after_m0");

        // Constant mode with tready toggling every cycle.
        mode = 2'd1; const_value = 8'hA5;
        start_frame();
        capture(40, 1, -1, -1);
        chk("m1_nbeat", nbeat, 32'd12);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("m1_data%0d", k), {24'd0, bd[k]}, 32'hA5);
            chk($sformatf("m1_cyc%0d", k), bc[k], 2 * k);
            chk($sformatf("m1_last%0d", k), {31'd0, bl[k]}, {31'd0, (k % 4) == 3});
        end
        chk("m1_stall_stable", viol, 32'd0);
        chk("m1_ndone", ndone, 32'd1);
        chk("m1_done_cyc", dc[0], 32'd23);
        $display("[TB] step mode1 toggle: beats=%0d viol=%0d", nbeat, viol);
        wait_idle("idle_after_m1");

        // Line blanking of two cycles on the second DUT.
        sel = 1; mode = 2'd0;
        start_frame();
        capture(24, 0, -1, -1);
        chk("hb_nbeat", nbeat, 32'd12);
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("hb_cyc%0d", k), bc[k], k + 2 * (k / 4));
            chk($sformatf("hb_data%0d", k), {24'd0, bd[k]}, (k / 4) + (k % 4));
        end
        chk("hb_ndone", ndone, 32'd1);
        chk("hb_done_cyc", dc[0], 32'd16);
        $display("[TB] step hblank: beats=%0d done_cyc=%0d", nbeat, dc[0]);
        wait_idle("idle_after_hb");

        // Continuous row pattern, continuous dropped during the first frame.
        sel = 0; mode = 2'd3; continuous = 1'b1;
        start_frame();
        capture(40, 0, 5, -1);
        chk("ct_nbeat", nbeat, 32'd24);
        for (int k = 0; k < 24; k++) begin
            chk($sformatf("ct_cyc%0d", k), bc[k], (k < 12) ? k : k + 3);
            chk($sformatf("ct_data%0d", k), {24'd0, bd[k]}, (k % 12) / 4);
            chk($sformatf("ct_user%0d", k), {31'd0, bu[k]}, {31'd0, (k % 12) == 0});
        end
        chk("ct_ndone", ndone, 32'd2);
        chk("ct_done0", dc[0], 32'd12);
        chk("ct_done1", dc[1], 32'd27);
        chk("ct_busy_end", {31'd0, s_busy}, 32'd0);
        $display("[TB] step continuous: beats=%0d frames=%0d", nbeat, ndone);
        wait_idle("idle_after_ct");

        // Asynchronous reset while stalled on beat 6.
        mode = 2'd0; continuous = 1'b0;
        start_frame();
        capture(5, 0, -1, -1);
        tready = 1'b0;
        chk("ar_pre_tvalid", {31'd0, a_tvalid}, 32'd1);
        chk("ar_pre_tdata",  {24'd0, a_tdata},  32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_tvalid", {31'd0, a_tvalid}, 32'd0);
        chk("ar_busy",   {31'd0, a_busy},   32'd0);
        chk("ar_tdata",  {24'd0, a_tdata},  32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tready = 1'b1;
        @(posedge clk); #1;
        start_frame();
        chk("ar_first_tdata", {24'd0, a_tdata}, 32'd0);
        chk("ar_first_tuser", {31'd0, a_tuser}, 32'd1);
        capture(20, 0, -1, -1);
        chk("ar_nbeat", nbeat, 32'd12);
        for (int k = 0; k < 12; k++)
            chk($sformatf("ar_data%0d", k), {24'd0, bd[k]}, {24'd0, e034[k]});
        chk("ar_ndone", ndone, 32'd1);
        $display("[TB] step async reset: beats=%0d", nbeat);
        wait_idle("idle_after_ar");

        // Start pulsed mid-frame must be ignored.
        mode = 2'd2;
        start_frame();
        capture(30, 0, -1, 3);
        chk("st_nbeat", nbeat, 32'd12);
        for (int k = 0; k < 12; k++)
            chk($sformatf("st_data%0d", k), {24'd0, bd[k]}, k % 4);
        chk("st_ndone", ndone, 32'd1);
        chk("st_busy_end", {31'd0, a_busy}, 32'd0);
        $display("[TB] step start ignored: beats=%0d done=%0d", nbeat, ndone);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
